// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, sizing helpers and register bit positions for tpuv2_ctrl
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_e;

    // Decoded meaning of one bus access (region combined with direction)
    typedef enum logic [2:0] {
        ACC_BAD,
        ACC_A_WR,
        ACC_B_WR,
        ACC_C_WR,
        ACC_C_RD,
        ACC_CMD_WR,
        ACC_STAT_RD,
        ACC_PERF_RD
    } acc_e;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam int CMD_START = 0;
    localparam int CMD_CLEAR = 1;
    localparam int CMD_PCLR  = 2;

    // Bus words needed to carry one row of C accumulators
    function automatic int cwpr_f(input int dim, input int bits_c, input int dataw);
        return (dim * bits_c + dataw - 1) / dataw;
    endfunction

    // Select width that never collapses to zero bits
    function automatic int selw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic in_win(input int unsigned a, input int unsigned base,
                                    input int unsigned size);
        return (a >= base) && (a < base + size);
    endfunction

endpackage

// File: rtl/tpuv2_ctrl_if.sv
// rtl/tpuv2_ctrl_if.sv - host bus request/response bundle for tpuv2_ctrl
interface tpuv2_ctrl_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             valid;
    logic             r_w;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] dataIn;
    logic             ready;
    logic             rd_valid;
    logic [DATAW-1:0] dataOut;

    modport master (
        output valid, r_w, addr, dataIn,
        input  ready, rd_valid, dataOut
    );

    modport slave (
        input  valid, r_w, addr, dataIn,
        output ready, rd_valid, dataOut
    );
endinterface

// File: rtl/tpu_addr_decode.sv
// rtl/tpu_addr_decode.sv - combinational region decode and row/word index for tpuv2_ctrl (perf window under TPU_PERF_CNT_EN)
module tpu_addr_decode
    import tpu_pkg::*;
#(
    parameter int          BITS_C   = 16,
    parameter int          DIM      = 8,
    parameter int          ADDRW    = 16,
    parameter int          DATAW    = 64,
    parameter int unsigned BASE_A   = 'h100,
    parameter int unsigned BASE_B   = 'h200,
    parameter int unsigned BASE_C   = 'h300,
    parameter int unsigned REG_CMD  = 'h400,
    parameter int unsigned REG_STAT = 'h408,
    localparam int         CWPR     = cwpr_f(DIM, BITS_C, DATAW),
    localparam int         ROWW     = selw_f(DIM),
    localparam int         CWW      = selw_f(CWPR)
) (
    input  logic [ADDRW-1:0] addr,
    input  logic             r_w,
    output acc_e             acc,
    output logic [ROWW-1:0]  row,
    output logic [CWW-1:0]   word
);
    localparam int unsigned BPW    = DATAW / 8;
    localparam int unsigned WIN_AB = DIM * BPW;
    localparam int unsigned WIN_C  = DIM * CWPR * BPW;
    localparam logic [ADDRW-1:0] BPW_W  = ADDRW'(BPW);
    localparam logic [ADDRW-1:0] CWPR_W = ADDRW'(CWPR);

    logic [ADDRW-1:0] off;
    logic [ADDRW-1:0] idx;
    logic [ADDRW-1:0] crow;
    logic [ADDRW-1:0] cword;
    int unsigned      a32;

    // Pick the region, then turn the byte offset into a word index
    always_comb begin
        acc = ACC_BAD;
        off = '0;
        a32 = 32'(addr);
        if (in_win(a32, BASE_A, WIN_AB)) begin
            acc = r_w ? ACC_A_WR : ACC_BAD;
            off = addr - ADDRW'(BASE_A);
        end else if (in_win(a32, BASE_B, WIN_AB)) begin
            acc = r_w ? ACC_B_WR : ACC_BAD;
            off = addr - ADDRW'(BASE_B);
        end else if (in_win(a32, BASE_C, WIN_C)) begin
            acc = r_w ? ACC_C_WR : ACC_C_RD;
            off = addr - ADDRW'(BASE_C);
        end else if (a32 == REG_CMD) begin
            acc = r_w ? ACC_CMD_WR : ACC_BAD;
        end else if (a32 == REG_STAT) begin
            acc = r_w ? ACC_BAD : ACC_STAT_RD;
`ifdef TPU_PERF_CNT_EN
        end else if (a32 == REG_STAT + 8) begin
            acc = r_w ? ACC_BAD : ACC_PERF_RD;
`endif
        end
        idx   = off / BPW_W;
        crow  = idx / CWPR_W;
        cword = idx % CWPR_W;
        row   = ((acc == ACC_C_WR) || (acc == ACC_C_RD)) ? ROWW'(crow) : ROWW'(idx);
        word  = CWW'(cword);
    end
endmodule

// File: rtl/tpuv2_ctrl.sv
// rtl/tpuv2_ctrl.sv - command decoder and compute sequencer for the systolic TPU (optional cycle counter: TPU_PERF_CNT_EN)
module tpuv2_ctrl
    import tpu_pkg::*;
#(
    parameter int          BITS_AB  = 8,
    parameter int          BITS_C   = 16,
    parameter int          DIM      = 8,
    parameter int          ADDRW    = 16,
    parameter int          DATAW    = 64,
    parameter int unsigned BASE_A   = 'h100,
    parameter int unsigned BASE_B   = 'h200,
    parameter int unsigned BASE_C   = 'h300,
    parameter int unsigned REG_CMD  = 'h400,
    parameter int unsigned REG_STAT = 'h408,
    localparam int         CWPR     = cwpr_f(DIM, BITS_C, DATAW),
    localparam int         ROWW     = selw_f(DIM),
    localparam int         CWW      = selw_f(CWPR)
) (
    input  logic             clk,
    input  logic             rst_n,
    tpuv2_ctrl_if.slave      bus,
    input  logic [DATAW-1:0] c_rdata,
    output logic             a_en,
    output logic             a_wren,
    output logic [ROWW-1:0]  a_row,
    output logic             b_en,
    output logic             sa_en,
    output logic             sa_wren,
    output logic             sa_clr,
    output logic [ROWW-1:0]  c_row,
    output logic [CWW-1:0]   c_word,
    output logic             done
);
    localparam int CNTW = $clog2(3 * DIM);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(3 * DIM - 3);

    state_e           state_q, state_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             a_pulse_q, a_pulse_d;
    logic [ROWW-1:0]  a_row_q, a_row_d;
    logic             b_pulse_q, b_pulse_d;
    logic             sa_wren_q, sa_wren_d;
    logic [ROWW-1:0]  c_row_q, c_row_d;
    logic [CWW-1:0]   c_word_q, c_word_d;
    logic             c_rd_pend_q, c_rd_pend_d;
    logic             rd_valid_q, rd_valid_d;
    logic [DATAW-1:0] dout_q, dout_d;
    logic             done_sticky_q, done_sticky_d;
    logic             err_sticky_q, err_sticky_d;

    acc_e             acc;
    logic [ROWW-1:0]  dec_row;
    logic [CWW-1:0]   dec_word;
    logic             busy, run, resp_now, anytime, ready_c, fire;
    logic [DATAW-1:0] perf_rd;
    logic             unused_ok;

    tpu_addr_decode #(
        .BITS_C  (BITS_C),
        .DIM     (DIM),
        .ADDRW   (ADDRW),
        .DATAW   (DATAW),
        .BASE_A  (BASE_A),
        .BASE_B  (BASE_B),
        .BASE_C  (BASE_C),
        .REG_CMD (REG_CMD),
        .REG_STAT(REG_STAT)
    ) u_dec (
        .addr(bus.addr),
        .r_w (bus.r_w),
        .acc (acc),
        .row (dec_row),
        .word(dec_word)
    );

    // Only the low command bits matter here
    assign unused_ok = ^bus.dataIn;

    assign busy     = (state_q != ST_IDLE);
    assign run      = (state_q == ST_RUN);
    assign resp_now = !bus.r_w && (acc != ACC_C_RD);
    assign anytime  = (acc == ACC_STAT_RD) || (acc == ACC_PERF_RD);
    // A one-cycle read may not land on top of the C read issued just before it
    assign ready_c  = rst_n && (!busy || anytime) && !(c_rd_pend_q && resp_now);
    assign fire     = bus.valid && ready_c;

`ifdef TPU_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of non-idle cycles, cleared from the command register
    always_comb begin
        perf_d = perf_q;
        if (fire && (acc == ACC_CMD_WR) && bus.dataIn[CMD_PCLR]) begin
            perf_d = '0;
        end else if (busy && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_rd = DATAW'(perf_q);
`else
    assign perf_rd = '0;
`endif

    // Sequencer next state: clear pulse, fixed-length run, done pulse
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (fire && (acc == ACC_CMD_WR) && bus.dataIn[CMD_START]) begin
                    state_d = bus.dataIn[CMD_CLEAR] ? ST_CLEAR : ST_RUN;
                    count_d = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
                count_d = '0;
            end
            ST_RUN: begin
                if (count_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNTW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Access side effects, read responses and sticky status bits
    always_comb begin
        a_pulse_d   = fire && (acc == ACC_A_WR);
        a_row_d     = a_pulse_d ? dec_row : a_row_q;
        b_pulse_d   = fire && (acc == ACC_B_WR);
        sa_wren_d   = fire && (acc == ACC_C_WR);
        c_rd_pend_d = fire && (acc == ACC_C_RD);
        c_row_d     = c_row_q;
        c_word_d    = c_word_q;
        if (sa_wren_d || c_rd_pend_d) begin
            c_row_d  = dec_row;
            c_word_d = dec_word;
        end

        rd_valid_d = 1'b0;
        dout_d     = '0;
        if (c_rd_pend_q) begin
            rd_valid_d = 1'b1;
            dout_d     = c_rdata;
        end else if (fire && resp_now) begin
            rd_valid_d = 1'b1;
            if (acc == ACC_STAT_RD) dout_d = DATAW'({err_sticky_q, done_sticky_q, busy});
            else if (acc == ACC_PERF_RD) dout_d = perf_rd;
        end

        done_sticky_d = done_sticky_q;
        err_sticky_d  = err_sticky_q;
        if (fire && (acc == ACC_STAT_RD)) begin
            done_sticky_d = 1'b0;
            err_sticky_d  = 1'b0;
        end
        if (state_q == ST_DONE)        done_sticky_d = 1'b1;
        if (fire && (acc == ACC_BAD))  err_sticky_d  = 1'b1;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            a_pulse_q     <= 1'b0;
            a_row_q       <= '0;
            b_pulse_q     <= 1'b0;
            sa_wren_q     <= 1'b0;
            c_row_q       <= '0;
            c_word_q      <= '0;
            c_rd_pend_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
            dout_q        <= '0;
            done_sticky_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            a_pulse_q     <= a_pulse_d;
            a_row_q       <= a_row_d;
            b_pulse_q     <= b_pulse_d;
            sa_wren_q     <= sa_wren_d;
            c_row_q       <= c_row_d;
            c_word_q      <= c_word_d;
            c_rd_pend_q   <= c_rd_pend_d;
            rd_valid_q    <= rd_valid_d;
            dout_q        <= dout_d;
            done_sticky_q <= done_sticky_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign bus.ready    = ready_c;
    assign bus.rd_valid = rd_valid_q;
    assign bus.dataOut  = dout_q;
    assign a_en         = a_pulse_q | run;
    assign a_wren       = a_pulse_q;
    assign a_row        = a_row_q;
    assign b_en         = b_pulse_q | run;
    assign sa_en        = run;
    assign sa_wren      = sa_wren_q;
    assign sa_clr       = (state_q == ST_CLEAR);
    assign c_row        = c_row_q;
    assign c_word       = c_word_q;
    assign done         = (state_q == ST_DONE);
endmodule
